// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA/SVGA timing generator.
// Holds the standard mode timings and an elaboration-time helper that checks whether an
// axis timing fits within its total and within the counter width.
// No ports.
package vga_timing_pkg;

   // SVGA 800x600@60
   localparam int unsigned SVGA_H_ACTIVE = 800;
   localparam int unsigned SVGA_H_FP     = 40;
   localparam int unsigned SVGA_H_SYNC   = 128;
   localparam int unsigned SVGA_H_TOTAL  = 1056;
   localparam int unsigned SVGA_V_ACTIVE = 600;
   localparam int unsigned SVGA_V_FP     = 1;
   localparam int unsigned SVGA_V_SYNC   = 4;
   localparam int unsigned SVGA_V_TOTAL  = 628;

   // VGA 640x480@60
   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_TOTAL  = 800;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_TOTAL  = 525;

   // True when active+fp+sync fits in total and total fits in a cnt_w-bit counter.
   function automatic bit axis_fits(input int unsigned active, input int unsigned fp,
                                    input int unsigned sync, input int unsigned total,
                                    input int unsigned cnt_w);
      logic [63:0] sum;
      logic [63:0] lim;
      sum = 64'(active) + 64'(fp) + 64'(sync);
      lim = 64'(1) << cnt_w;
      return (sum <= 64'(total)) && (64'(total) <= lim) && (total > 0);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical) of the sync generator.
// Ports:
//   CLK    in   clock
//   RST_N  in   asynchronous active-low reset
//   step   in   advance the counter by one position this cycle
//   count  out  current position, 0..TOTAL-1 (resets to TOTAL-1)
//   wrap   out  combinational: step is high and count is at TOTAL-1 (next position is 0)
//   sync   out  registered sync level for the position shown on count
//   active out  combinational: the position count will hold after this cycle is visible
module vga_axis_counter #(
   parameter int unsigned ACTIVE = 800,
   parameter int unsigned FP     = 40,
   parameter int unsigned SYNC   = 128,
   parameter int unsigned TOTAL  = 1056,
   parameter logic        POL    = 1'b1,
   parameter int unsigned CNT_W  = 12
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             step,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             sync,
   output logic             active
);

   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
   // One extra bit so that a sync window ending exactly at 2^CNT_W does not alias to 0.
   localparam logic [CNT_W:0]   ACT_END  = (CNT_W+1)'(ACTIVE);
   localparam logic [CNT_W:0]   SYNC_BEG = (CNT_W+1)'(ACTIVE + FP);
   localparam logic [CNT_W:0]   SYNC_END = (CNT_W+1)'(ACTIVE + FP + SYNC);

   logic [CNT_W-1:0] count_next;
   logic [CNT_W:0]   next_ext;
   logic             sync_next;

   always_comb begin
      wrap       = step && (count == LAST);
      count_next = count;
      if (wrap) begin
         count_next = '0;
      end else if (step) begin
         count_next = count + CNT_W'(1);
      end
      next_ext  = {1'b0, count_next};
      active    = (next_ext < ACT_END);
      sync_next = ((next_ext >= SYNC_BEG) && (next_ext < SYNC_END)) ? POL : ~POL;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= LAST;
         sync  <= ~POL;
      end else if (step) begin
         count <= count_next;
         sync  <= sync_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. All outputs are registered from the next counter values,
// so sync, de and strobes always describe the pixel shown on pixel_x/pixel_y.
// Optional feature macro: VGA_TIMING_SYNC_DELAY_EN -- when defined, h_sync, v_sync and de are
// delayed by SYNC_DELAY enabled cycles to match a pixel pipeline; coordinates and strobes are not.
// Ports:
//   CLK          in   pixel clock
//   RST_N        in   asynchronous active-low reset
//   pix_en       in   pixel clock-enable; all state holds while low
//   h_sync       out  horizontal sync, active level H_POL
//   v_sync       out  vertical sync, active level V_POL
//   de           out  data enable, high on visible pixels
//   pixel_x      out  current column
//   pixel_y      out  current line
//   line_start   out  pulse (one enabled cycle) when pixel_x == 0
//   frame_start  out  pulse (one enabled cycle) when pixel_x == 0 and pixel_y == 0
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned H_ACTIVE   = SVGA_H_ACTIVE,
   parameter int unsigned H_FP       = SVGA_H_FP,
   parameter int unsigned H_SYNC     = SVGA_H_SYNC,
   parameter int unsigned H_TOTAL    = SVGA_H_TOTAL,
   parameter logic        H_POL      = 1'b1,
   parameter int unsigned V_ACTIVE   = SVGA_V_ACTIVE,
   parameter int unsigned V_FP       = SVGA_V_FP,
   parameter int unsigned V_SYNC     = SVGA_V_SYNC,
   parameter int unsigned V_TOTAL    = SVGA_V_TOTAL,
   parameter logic        V_POL      = 1'b1,
   parameter int unsigned SYNC_DELAY = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             pix_en,
   output logic             h_sync,
   output logic             v_sync,
   output logic             de,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start
);

   if (!axis_fits(H_ACTIVE, H_FP, H_SYNC, H_TOTAL, CNT_W)) begin : g_bad_h
      $error("vga_timing_gen: horizontal timing does not fit H_TOTAL or CNT_W");
   end
   if (!axis_fits(V_ACTIVE, V_FP, V_SYNC, V_TOTAL, CNT_W)) begin : g_bad_v
      $error("vga_timing_gen: vertical timing does not fit V_TOTAL or CNT_W");
   end

   logic h_wrap, v_wrap, v_step;
   logic h_sync_raw, v_sync_raw;
   logic h_active, v_active;
   logic de_q, line_start_q, frame_start_q;

   // The vertical axis steps on the horizontal wrap, so v_sync only changes where x becomes 0.
   assign v_step = h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .TOTAL  (H_TOTAL),
      .POL    (H_POL),
      .CNT_W  (CNT_W)
   ) u_h_axis (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .step   (pix_en),
      .count  (pixel_x),
      .wrap   (h_wrap),
      .sync   (h_sync_raw),
      .active (h_active)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .TOTAL  (V_TOTAL),
      .POL    (V_POL),
      .CNT_W  (CNT_W)
   ) u_v_axis (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .step   (v_step),
      .count  (pixel_y),
      .wrap   (v_wrap),
      .sync   (v_sync_raw),
      .active (v_active)
   );

   // h_wrap / v_wrap mean the next position is x==0 / (0,0); strobes hold while pix_en is low.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (pix_en) begin
         de_q          <= h_active && v_active;
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
      end
   end

   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_SYNC_DELAY_EN
   if (SYNC_DELAY == 0) begin : g_no_delay
      assign h_sync = h_sync_raw;
      assign v_sync = v_sync_raw;
      assign de     = de_q;
   end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe, de_pipe;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            hs_pipe <= {SYNC_DELAY{~H_POL}};
            vs_pipe <= {SYNC_DELAY{~V_POL}};
            de_pipe <= '0;
         end else if (pix_en) begin
            hs_pipe[0] <= h_sync_raw;
            vs_pipe[0] <= v_sync_raw;
            de_pipe[0] <= de_q;
            for (int i = 1; i < int'(SYNC_DELAY); i++) begin
               hs_pipe[i] <= hs_pipe[i-1];
               vs_pipe[i] <= vs_pipe[i-1];
               de_pipe[i] <= de_pipe[i-1];
            end
         end
      end

      assign h_sync = hs_pipe[SYNC_DELAY-1];
      assign v_sync = vs_pipe[SYNC_DELAY-1];
      assign de     = de_pipe[SYNC_DELAY-1];
   end
`else
   assign h_sync = h_sync_raw;
   assign v_sync = v_sync_raw;
   assign de     = de_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small mode (H 8/2/3/16, V 4/1/2/10) checked pixel by
// pixel against hand-derived expectations, plus a default SVGA instance checked over 3 lines.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s, en_s, rst_b, en_b;
   logic        hs_s, vs_s, de_s, ls_s, fs_s;
   logic [11:0] x_s, y_s;
   logic        hs_b, vs_b, de_b, ls_b, fs_b;
   logic [11:0] x_b, y_b;

   int n_checks = 0;
   int n_pass   = 0;

   vga_timing_gen #(
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_TOTAL  (16),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_TOTAL  (10)
   ) u_small (
      .CLK         (clk),
      .RST_N       (rst_s),
      .pix_en      (en_s),
      .h_sync      (hs_s),
      .v_sync      (vs_s),
      .de          (de_s),
      .pixel_x     (x_s),
      .pixel_y     (y_s),
      .line_start  (ls_s),
      .frame_start (fs_s)
   );

   vga_timing_gen u_svga (
      .CLK         (clk),
      .RST_N       (rst_b),
      .pix_en      (en_b),
      .h_sync      (hs_b),
      .v_sync      (vs_b),
      .de          (de_b),
      .pixel_x     (x_b),
      .pixel_y     (y_b),
      .line_start  (ls_b),
      .frame_start (fs_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // idx = enabled cycles since reset release minus one (idx 0 is the first presented pixel).
   task automatic check_small(input int idx);
      int ex, ey, sx, sy;
      bit hs_e, vs_e, de_e;
      ex = idx % 16;
      ey = (idx / 16) % 10;
      hs_e = 1'b0;
      vs_e = 1'b0;
      de_e = 1'b0;
      if (idx >= DLY) begin
         sx   = (idx - DLY) % 16;
         sy   = ((idx - DLY) / 16) % 10;
         hs_e = (sx >= 10) && (sx < 13);
         vs_e = (sy >= 5) && (sy < 7);
         de_e = (sx < 8) && (sy < 4);
      end
      check($sformatf("x@%0d", idx), x_s, ex);
      check($sformatf("y@%0d", idx), y_s, ey);
      check($sformatf("h_sync@%0d", idx), hs_s, hs_e);
      check($sformatf("v_sync@%0d", idx), vs_s, vs_e);
      check($sformatf("de@%0d", idx), de_s, de_e);
      check($sformatf("line_start@%0d", idx), ls_s, ex == 0);
      check($sformatf("frame_start@%0d", idx), fs_s, (ex == 0) && (ey == 0));
   endtask

   task automatic check_small_reset(input string tag);
      check({tag, "_x"}, x_s, 15);
      check({tag, "_y"}, y_s, 9);
      check({tag, "_hs"}, hs_s, 0);
      check({tag, "_vs"}, vs_s, 0);
      check({tag, "_de"}, de_s, 0);
      check({tag, "_ls"}, ls_s, 0);
      check({tag, "_fs"}, fs_s, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_small();
      @(negedge clk);
      rst_s = 1'b0;
      en_s  = 1'b0;
      @(negedge clk);
      rst_s = 1'b1;
   endtask

   initial begin
      int prev_vs, toggles, m, ls_cnt, cyc, hs_cnt, de_cnt;
      bit pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      rst_s = 1'b0;
      en_s  = 1'b0;
      rst_b = 1'b0;
      en_b  = 1'b1;
      tick();
      tick();
      check_small_reset("rst");
      check("svga_rst_x", x_b, 1055);
      check("svga_rst_y", y_b, 627);
      check("svga_rst_hs", hs_b, 0);
      check("svga_rst_vs", vs_b, 0);
      check("svga_rst_de", de_b, 0);

      // One full frame plus the first pixel of the next, pix_en held high.
      @(negedge clk);
      rst_s = 1'b1;
      en_s  = 1'b1;
      prev_vs = 0;
      toggles = 0;
      for (int idx = 0; idx <= 160; idx++) begin
         tick();
         check_small(idx);
         if (int'(vs_s) != prev_vs) begin
            toggles++;
            check($sformatf("vs_toggle_x@%0d", idx), x_s, 0);
         end
         prev_vs = int'(vs_s);
      end
      check("vs_toggles_per_frame", toggles, 2);

      // pix_en pattern 1,0,0,1: state only moves on enabled cycles, strobes hold otherwise.
      reset_small();
      m = 0;
      ls_cnt = 0;
      cyc = 0;
      while (m < 161 && cyc < 1000) begin
         @(negedge clk);
         en_s = pat[cyc % 4];
         tick();
         if (en_s) begin
            m++;
            if (ls_s) ls_cnt++;
         end
         if (m > 0) check_small(m - 1);
         cyc++;
      end
      check("en_pattern_done", m, 161);
      check("ls_enabled_cycles", ls_cnt, 11);

      // Reset asserted while showing (5,3).
      @(negedge clk);
      en_s = 1'b1;
      reset_small();
      en_s = 1'b1;
      for (int idx = 0; idx <= 53; idx++) begin
         tick();
         check_small(idx);
      end
      #2;
      rst_s = 1'b0;
      #1;
      check_small_reset("midrst_now");
      for (int k = 0; k < 3; k++) begin
         tick();
         check_small_reset("midrst_hold");
      end
      @(negedge clk);
      rst_s = 1'b1;
      for (int idx = 0; idx <= 3; idx++) begin
         tick();
         check_small(idx);
      end

      // Default SVGA mode over the first 3 lines.
      @(negedge clk);
      rst_b  = 1'b1;
      hs_cnt = 0;
      de_cnt = 0;
      for (int c = 0; c < 3168; c++) begin
         tick();
         if (c == 0) begin
            check("svga_first_x", x_b, 0);
            check("svga_first_y", y_b, 0);
            check("svga_first_fs", fs_b, 1);
            check("svga_first_de", de_b, (DLY == 0) ? 1 : 0);
         end
         hs_cnt += int'(hs_b);
         de_cnt += int'(de_b);
      end
      check("svga_hs_count_3_lines", hs_cnt, 384);
      check("svga_de_count_3_lines", de_cnt, 2400);
      tick();
      check("svga_line3_x", x_b, 0);
      check("svga_line3_y", y_b, 3);
      check("svga_line3_ls", ls_b, 1);
      check("svga_line3_vs", vs_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed-mode VGA sync generator. Produces h_sync, v_sync, data-enable, pixel coordinates and line/frame strobes from a single clock, with a pixel clock-enable for divided pixel rates. It sits between the clock tree and the pixel/framebuffer pipeline. All outputs are registered and mutually aligned, so there is no one-line v_sync skew.

Parameters:
CNT_W, 12, width of coordinate counters and pixel_x/pixel_y
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_TOTAL, 1056, total pixels per line
H_POL, 1'b1, h_sync active level
V_ACTIVE, 600, visible lines
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_TOTAL, 628, total lines per frame
V_POL, 1'b1, v_sync active level
SYNC_DELAY, 2, enabled-cycle delay applied to sync/de (only with the optional feature)

Ports:
CLK  in  1  pixel clock
RST_N  in  1  asynchronous active-low reset
pix_en  in  1  pixel clock-enable; all state holds when low
h_sync  out  1  horizontal sync, polarity H_POL
v_sync  out  1  vertical sync, polarity V_POL
de  out  1  data enable; high on visible pixels
pixel_x  out  CNT_W  current column, 0..H_TOTAL-1
pixel_y  out  CNT_W  current line, 0..V_TOTAL-1
line_start  out  1  one enabled-cycle pulse when pixel_x==0
frame_start  out  1  one enabled-cycle pulse when pixel_x==0 && pixel_y==0

Behaviour:
- Reset (async assert, sync-released on CLK):
  - pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1.
  - h_sync=~H_POL, v_sync=~V_POL.
  - de=0, line_start=0, frame_start=0.
- The first enabled cycle after release presents (0,0) with frame_start=1, line_start=1, de=1.
- Counters:
  - pixel_x increments per enabled cycle and wraps H_TOTAL-1 -> 0.
  - pixel_y increments only on the x wrap and wraps V_TOTAL-1 -> 0.
  - The simultaneous x and y wrap yields (0,0).
- All outputs are registered and computed from the next counter values, so in every cycle they describe the pixel shown on pixel_x/pixel_y (zero relative latency):
  - h_sync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - v_sync active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. It changes only on cycles where x becomes 0.
  - de = (x < H_ACTIVE) && (y < V_ACTIVE).
- pix_en low: counters and all outputs hold. Strobes also hold, so a strobe lasts exactly one enabled cycle.
- Reset asserted mid-frame: immediate return to the reset values above; no partial sync pulse persists.
- Elaboration checks ($error) reject parameters that violate either:
  - H_ACTIVE+H_FP+H_SYNC <= H_TOTAL, or the V equivalent;
  - H_TOTAL or V_TOTAL exceeding 2^CNT_W.

Optional Feature:
- Macro: VGA_TIMING_SYNC_DELAY_EN.
- Defined:
  - h_sync, v_sync and de pass through a SYNC_DELAY-stage shift register advanced only on pix_en, to match the pixel pipeline latency.
  - pixel_x, pixel_y and the strobes are not delayed.
  - Stages reset to inactive levels (~H_POL, ~V_POL, 0).
- Undefined: no delay; SYNC_DELAY is ignored.

Decomposition:
- Shared package vga_timing_pkg holds the mode constants:
  - SVGA 800x600@60: 800/40/128/1056, 600/1/4/628.
  - VGA 640x480@60: 640/16/96/800, 480/10/2/525.
- Sub-module vga_axis_counter, instantiated twice (H and V):
  - params ACTIVE, FP, SYNC, TOTAL, POL, CNT_W;
  - inputs step, RST_N;
  - outputs count, wrap, sync, active.

Test Plan:
- Small mode, H 8/2/3/16 and V 4/1/2/10, pix_en=1: after reset the first cycle is (0,0), frame_start=1; h_sync active for x=10..12 only; de high for x<8 && y<4; frame period exactly 160 cycles.
- Same mode: v_sync rises in the cycle where (x,y)=(0,5), falls at (0,7), and never toggles when x!=0.
- pix_en toggled 1,0,0,1 repeatedly: counters advance once per enabled cycle; each line_start is high for exactly one enabled cycle; the frame takes 160 enabled cycles.
- RST_N pulsed low at (5,3) for 3 cycles: outputs go to reset values immediately; after release the first enabled cycle is (0,0) with frame_start=1.
- Default SVGA mode over 2 frames: h_sync count 1256; v_sync width 4*1056 cycles; de count 960000.
- With VGA_TIMING_SYNC_DELAY_EN and SYNC_DELAY=2 in the small mode: h_sync active for x=12..14 (enabled cycles); pixel_x is unchanged relative to the undelayed build.
